csel_adder_pipe: RTL and testbench

//  Parametrised, two-stage pipelined carry-select adder/subtractor with valid/ready flow control.

---
 rtl/csel_adder_pipe_if.sv | 37 +++
 rtl/csel_adder_pipe.sv | 145 ++++++++++++++
 tb/tb_csel_adder_pipe.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/csel_adder_pipe_if.sv
// rtl/csel_adder_pipe_if.sv - operand/result handshake bundle for csel_adder_pipe
//
// Purpose: groups the input operation channel and the output result channel
// of the pipelined carry-select adder into one interface.
// Signals:
//   in_valid/in_ready   input operation handshake
//   a, b, cin, sub      operands, carry-in and subtract select
//   out_valid/out_ready result handshake
//   sum, cout, ovf      result, carry-out of MSB, signed overflow
// Modports:
//   master  producer of operations / consumer of results
//   slave   the adder itself
interface csel_adder_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/csel_adder_pipe.sv
// rtl/csel_adder_pipe.sv - two-stage pipelined carry-select adder/subtractor
//
// Purpose: WIDTH-bit a+b+cin or a-b with valid/ready flow control.
//   Stage A precomputes, for every BLOCK-bit group, the sum and carry for a
//   group carry-in of 0 and of 1. Stage B walks the group carries by mux
//   selection and registers sum/cout/ovf. Latency 2, throughput 1/cycle.
// Ports:
//   clk   clock, rising edge
//   rst   synchronous reset, active-high
//   bus   csel_adder_pipe_if.slave (in_valid/in_ready/a/b/cin/sub,
//         out_valid/out_ready/sum/cout/ovf)
module csel_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input logic              clk,
    input logic              rst,
    csel_adder_pipe_if.slave bus
);
    localparam int NG = WIDTH / BLOCK;
    localparam logic [BLOCK:0] ONE = 1;

    generate
        if ((WIDTH % BLOCK) != 0 || WIDTH < BLOCK) begin : g_bad_params
            $error("csel_adder_pipe: WIDTH must be a nonzero multiple of BLOCK");
        end
    endgenerate

    // Flow control: a stage may load when it is empty or its content leaves.
    logic va;
    logic vb;
    logic adv_a;
    logic adv_b;

    assign adv_b        = !vb || bus.out_ready;
    assign adv_a        = !va || adv_b;
    assign bus.in_ready = adv_a;

    // Stage A: conditional group sums.
    logic [WIDTH-1:0]            bx;
    logic                        c_in;
    logic [NG-1:0][BLOCK-1:0]    s0_d;
    logic [NG-1:0][BLOCK-1:0]    s1_d;
    logic [NG-1:0]               gc0_d;
    logic [NG-1:0]               gc1_d;
    logic                        mc0_d;
    logic                        mc1_d;

    always_comb begin
        bx    = bus.sub ? ~bus.b : bus.b;
        c_in  = bus.sub ? 1'b1 : bus.cin;
        s0_d  = '0;
        s1_d  = '0;
        gc0_d = '0;
        gc1_d = '0;
        for (int g = 0; g < NG; g++) begin
            {gc0_d[g], s0_d[g]} = {1'b0, bus.a[g*BLOCK +: BLOCK]} + {1'b0, bx[g*BLOCK +: BLOCK]};
            {gc1_d[g], s1_d[g]} = {1'b0, bus.a[g*BLOCK +: BLOCK]} + {1'b0, bx[g*BLOCK +: BLOCK]} + ONE;
        end
        // Carry into the MSB recovered from the MSB sum bit: c = s ^ a ^ bx.
        mc0_d = s0_d[NG-1][BLOCK-1] ^ bus.a[WIDTH-1] ^ bx[WIDTH-1];
        mc1_d = s1_d[NG-1][BLOCK-1] ^ bus.a[WIDTH-1] ^ bx[WIDTH-1];
    end

    logic [NG-1:0][BLOCK-1:0]    s0_q;
    logic [NG-1:0][BLOCK-1:0]    s1_q;
    logic [NG-1:0]               gc0_q;
    logic [NG-1:0]               gc1_q;
    logic                        mc0_q;
    logic                        mc1_q;
    logic                        cin_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            va    <= 1'b0;
            s0_q  <= '0;
            s1_q  <= '0;
            gc0_q <= '0;
            gc1_q <= '0;
            mc0_q <= 1'b0;
            mc1_q <= 1'b0;
            cin_q <= 1'b0;
        end else if (adv_a) begin
            va <= bus.in_valid;
            if (bus.in_valid) begin
                s0_q  <= s0_d;
                s1_q  <= s1_d;
                gc0_q <= gc0_d;
                gc1_q <= gc1_d;
                mc0_q <= mc0_d;
                mc1_q <= mc1_d;
                cin_q <= c_in;
            end
        end
    end

    // Stage B: resolve group carries from the LSB group upward.
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;

    always_comb begin : b_resolve
        logic sel;
        logic msb_c;
        sel   = cin_q;
        msb_c = 1'b0;
        sum_d = '0;
        for (int g = 0; g < NG; g++) begin
            sum_d[g*BLOCK +: BLOCK] = sel ? s1_q[g] : s0_q[g];
            if (g == NG - 1) begin
                msb_c = sel ? mc1_q : mc0_q;
            end
            sel = sel ? gc1_q[g] : gc0_q[g];
        end
        cout_d = sel;
        ovf_d  = msb_c ^ sel;
    end

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    // Result registers only load with a valid stage-A entry, so a held
    // result never changes while out_ready is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            vb     <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (adv_b) begin
            vb <= va;
            if (va) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign bus.out_valid = vb;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_csel_adder_pipe.sv
// tb/tb_csel_adder_pipe.sv - self-checking bench for csel_adder_pipe (WIDTH=16, BLOCK=4)
module tb_csel_adder_pipe;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csel_adder_pipe_if #(.WIDTH(W)) bus ();

    csel_adder_pipe #(.WIDTH(W), .BLOCK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] e_sum;
        logic         e_cout;
        logic         e_ovf;
    } vec_t;

    vec_t         tv[9];
    logic [W+1:0] sbq[$];
    int           tests = 0;
    int           fails = 0;
    int           n_out = 0;
    logic         acc;

    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        logic [W-1:0] bx;
        logic [W:0]   full;
        logic         ov;
        bx   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        ov   = (a[W-1] == bx[W-1]) && (full[W-1] != a[W-1]);
        return {ov, full[W], full[W-1:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard, sampled at the falling edge where inputs and outputs are stable.
    task automatic sample();
        logic [W+1:0] e;
        acc = 1'b0;
        if (rst) begin
            sbq.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (sbq.size() == 0) begin
                    check("sb_unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("sb_result", {14'd0, bus.ovf, bus.cout, bus.sum}, {14'd0, e});
                end
            end
            acc = bus.in_valid && bus.in_ready;
            if (acc) sbq.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
    endtask

    logic [W-1:0] bp_a[4];
    logic [W-1:0] bp_b[4];
    logic [W+1:0] e0;
    int           idx;
    int           base;
    int           guard;

    initial begin
        tv[0] = '{16'h1234, 16'h0FED, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b0};
        tv[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        tv[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tv[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tv[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tv[5] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tv[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        tv[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tv[8] = '{16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};

        rst           = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (3) cycle();
        rst = 1'b0;
        #1;
        check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset_sum", {16'd0, bus.sum}, 32'd0);
        check("reset_cout", {31'd0, bus.cout}, 32'd0);
        check("reset_ovf", {31'd0, bus.ovf}, 32'd0);
        check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Directed vectors with latency check.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, tv[i].a, tv[i].b, tv[i].cin, tv[i].sub);
            cycle();
            drive(1'b0, '0, '0, 1'b0, 1'b0);
            check("vec_latency_early", {31'd0, bus.out_valid}, 32'd0);
            cycle();
            check("vec_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("vec_sum", {16'd0, bus.sum}, {16'd0, tv[i].e_sum});
            check("vec_cout", {31'd0, bus.cout}, {31'd0, tv[i].e_cout});
            check("vec_ovf", {31'd0, bus.ovf}, {31'd0, tv[i].e_ovf});
            cycle();
        end

        // Back-pressure: 4 ops offered with out_ready low.
        bp_a = '{16'h0001, 16'h1111, 16'hABCD, 16'hFFFF};
        bp_b = '{16'h0002, 16'h2222, 16'h1234, 16'hFFFF};
        bus.out_ready = 1'b0;
        idx  = 0;
        base = n_out;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, bp_a[idx], bp_b[idx], 1'b0, 1'b0);
            cycle();
            if (acc) idx++;
        end
        check("bp_accepts", idx, 32'd2);
        check("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        e0 = model(bp_a[0], bp_b[0], 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_hold_sum", {16'd0, bus.sum}, {16'd0, e0[W-1:0]});
            cycle();
        end
        bus.out_ready = 1'b1;
        #1;
        check("full_pipe_in_ready", {31'd0, bus.in_ready}, 32'd1);
        guard = 0;
        while ((idx < 4 || sbq.size() != 0) && guard < 20) begin
            if (idx < 4) drive(1'b1, bp_a[idx], bp_b[idx], 1'b0, 1'b0);
            else         drive(1'b0, '0, '0, 1'b0, 1'b0);
            cycle();
            if (acc) idx++;
            guard++;
        end
        check("bp_drain_timeout", {31'd0, guard >= 20}, 32'd0);
        check("bp_outputs", n_out - base, 32'd4);
        drive(1'b0, '0, '0, 1'b0, 1'b0);

        // Reset with two operations in flight.
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h4444, 16'h5555, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 16'h0123, 16'h0FFF, 1'b0, 1'b1);
        cycle();
        check("mid_pipe_full", {31'd0, bus.out_valid}, 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_result", {14'd0, bus.ovf, bus.cout, bus.sum}, 32'd0);
        check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        cycle();
        check("midrst_stays_empty", {31'd0, bus.out_valid}, 32'd0);

        // Random traffic with random back-pressure.
        for (int c = 0; c < 4000; c++) begin
            drive(($urandom % 4) != 0, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            bus.out_ready = ($urandom % 3) != 0;
            cycle();
            if (sbq.size() > 2) check("inflight_bound", sbq.size(), 32'd2);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        guard = 0;
        while (sbq.size() != 0 && guard < 10) begin
            cycle();
            guard++;
        end
        check("random_drain", sbq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
